// File: rtl/muldiv_pkg.sv
// Shared constants and types for the M-extension multiply/divide sequencer.
package muldiv_pkg;

    localparam int DEF_XLEN = 64;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    // Most negative signed value at the default width.
    localparam logic [DEF_XLEN-1:0] INT_MIN = {1'b1, {(DEF_XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the execute stage and the muldiv sequencer.
interface muldiv_if #(
    parameter int XLEN = 64
);
    logic            REQ_V;
    logic [2:0]      REQ_OP;
    logic [XLEN-1:0] REQ_A;
    logic [XLEN-1:0] REQ_B;
    logic [4:0]      REQ_DR;
    logic            FLUSH;
    logic            REQ_READY;
    logic            MD_STALL;
    logic            RES_V;
    logic [XLEN-1:0] RES;
    logic [4:0]      RES_DR;

    // Pipeline side: issues requests, consumes results.
    modport master (
        output REQ_V, REQ_OP, REQ_A, REQ_B, REQ_DR, FLUSH,
        input  REQ_READY, MD_STALL, RES_V, RES, RES_DR
    );

    // Sequencer side.
    modport slave (
        input  REQ_V, REQ_OP, REQ_A, REQ_B, REQ_DR, FLUSH,
        output REQ_READY, MD_STALL, RES_V, RES, RES_DR
    );
endinterface

// File: rtl/muldiv_divu_iter.sv
// One restoring-division step on unsigned magnitudes.
module divu_iter #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rem,
    input  logic            dbit,
    input  logic [XLEN-1:0] dsr,
    output logic [XLEN-1:0] rem_nxt,
    output logic            qbit
);
    // Shifted remainder can reach 2*dsr-1, so keep one extra bit for the compare.
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // Shift in the next dividend bit and subtract when the divisor fits.
    always_comb begin
        shifted = {rem, dbit};
        diff    = shifted - {1'b0, dsr};
        qbit    = (shifted >= {1'b0, dsr});
        rem_nxt = qbit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    end
endmodule

// File: rtl/muldiv_sequencer.sv
// RISC-V M-extension sequencer: single-cycle multiply, 64-step restoring divide.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int CNT_W = 6
) (
    input  logic   CLK,
    input  logic   RESET_N,
    muldiv_if.slave bus
);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   dvd_q;     // dividend bits out, quotient bits in
    logic [XLEN-1:0]   dsr_q;     // divisor magnitude
    logic [XLEN-1:0]   rem_q;     // partial remainder
    logic              is_rem_q;
    logic              neg_q_q;
    logic              neg_r_q;
    logic [XLEN-1:0]   res_q;
    logic [4:0]        res_dr_q;

    logic              accept, is_mul, sgn_div, b_zero, ovf, fast;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   abs_a, abs_b, fast_res;
    logic [2*XLEN-1:0] a_ext, b_ext, prod;
    logic [XLEN-1:0]   rem_nxt, dvd_nxt, fix_res;
    logic              qbit;

    assign bus.REQ_READY = (state_q == IDLE);
    assign bus.MD_STALL  = ((state_q == IDLE) && bus.REQ_V && !bus.FLUSH) || (state_q == DIV);
    assign bus.RES_V     = (state_q == DONE) && !bus.FLUSH;
    assign bus.RES       = res_q;
    assign bus.RES_DR    = res_dr_q;

    // Decode the incoming request and precompute single-cycle results.
    always_comb begin
        accept  = (state_q == IDLE) && bus.REQ_V && !bus.FLUSH;
        is_mul  = !bus.REQ_OP[2];
        sgn_div = bus.REQ_OP[2] && !bus.REQ_OP[0];
        b_zero  = bus.REQ_OP[2] && (bus.REQ_B == '0);
        ovf     = sgn_div && (bus.REQ_A == SMIN) && (bus.REQ_B == '1);
        fast    = is_mul || b_zero || ovf;
        a_neg   = sgn_div && bus.REQ_A[XLEN-1];
        b_neg   = sgn_div && bus.REQ_B[XLEN-1];
        abs_a   = a_neg ? -bus.REQ_A : bus.REQ_A;
        abs_b   = b_neg ? -bus.REQ_B : bus.REQ_B;
        // MULH and MULHSU sign-extend rs1; only MULH sign-extends rs2.
        a_ext   = {{XLEN{(bus.REQ_OP == OP_MULH || bus.REQ_OP == OP_MULHSU) && bus.REQ_A[XLEN-1]}}, bus.REQ_A};
        b_ext   = {{XLEN{(bus.REQ_OP == OP_MULH) && bus.REQ_B[XLEN-1]}}, bus.REQ_B};
        prod    = a_ext * b_ext;
        if (is_mul)
            fast_res = (bus.REQ_OP == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        else if (b_zero)
            fast_res = bus.REQ_OP[1] ? bus.REQ_A : '1;
        else
            fast_res = bus.REQ_OP[1] ? '0 : bus.REQ_A;
    end

    divu_iter #(.XLEN(XLEN)) u_iter (
        .rem     (rem_q),
        .dbit    (dvd_q[XLEN-1]),
        .dsr     (dsr_q),
        .rem_nxt (rem_nxt),
        .qbit    (qbit)
    );

    // Sign fixup applied to the final iteration's outputs.
    always_comb begin
        dvd_nxt = {dvd_q[XLEN-2:0], qbit};
        if (is_rem_q)
            fix_res = neg_r_q ? -rem_nxt : rem_nxt;
        else
            fix_res = neg_q_q ? -dvd_nxt : dvd_nxt;
    end

    // State register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; FLUSH overrides everything.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = fast ? DONE : DIV;
            DIV:     if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.FLUSH) state_d = IDLE;
    end

    // Operand capture, divide iteration and result registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q    <= '0;
            dvd_q    <= '0;
            dsr_q    <= '0;
            rem_q    <= '0;
            is_rem_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            res_q    <= '0;
            res_dr_q <= '0;
        end else if (accept) begin
            res_dr_q <= bus.REQ_DR;
            is_rem_q <= bus.REQ_OP[1];
            neg_q_q  <= a_neg ^ b_neg;
            neg_r_q  <= a_neg;
            if (fast) begin
                res_q <= fast_res;
            end else begin
                dvd_q <= abs_a;
                dsr_q <= abs_b;
                rem_q <= '0;
                cnt_q <= CNT_W'(XLEN-1);
            end
        end else if (state_q == DIV && !bus.FLUSH) begin
            dvd_q <= dvd_nxt;
            rem_q <= rem_nxt;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) res_q <= fix_res;
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: multiply, divide, special cases, flush, reset.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    int tests_run = 0;
    int tests_failed = 0;

    muldiv_if #(.XLEN(64)) bus ();

    muldiv_sequencer #(.XLEN(64), .CNT_W(6)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus.slave)
    );

    always #5 CLK = ~CLK;

    // Issue one request after waiting for READY; report result, latency and stall behaviour.
    task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] dr, output logic [63:0] res, output logic [4:0] rdr,
                          output int lat, output logic stall_acc, output logic stall_gap,
                          output logic stall_done, output int wait_cyc);
        wait_cyc = 0;
        while (!bus.REQ_READY && wait_cyc < 200) begin
            @(posedge CLK); #1; wait_cyc++;
        end
        bus.REQ_V = 1'b1; bus.REQ_OP = op; bus.REQ_A = a; bus.REQ_B = b; bus.REQ_DR = dr;
        #1 stall_acc = bus.MD_STALL;
        @(posedge CLK); #1;
        bus.REQ_V = 1'b0;
        lat = 1;
        stall_gap = 1'b0;
        while (!bus.RES_V && lat < 200) begin
            if (!bus.MD_STALL) stall_gap = 1'b1;
            @(posedge CLK); #1; lat++;
        end
        res = bus.RES; rdr = bus.RES_DR; stall_done = bus.MD_STALL;
    endtask

    task automatic test_reset();
        #1;
        tests_run++; if (bus.RES_V !== 1'b0) begin tests_failed++; $display("FAIL reset_res_v got %b want 0", bus.RES_V); end
        tests_run++; if (bus.RES !== 64'd0) begin tests_failed++; $display("FAIL reset_res got %h want 0", bus.RES); end
        tests_run++; if (bus.RES_DR !== 5'd0) begin tests_failed++; $display("FAIL reset_res_dr got %0d want 0", bus.RES_DR); end
        tests_run++; if (bus.REQ_READY !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got %b want 1", bus.REQ_READY); end
        tests_run++; if (bus.MD_STALL !== 1'b0) begin tests_failed++; $display("FAIL reset_stall got %b want 0", bus.MD_STALL); end
        @(posedge CLK); #1 RESET_N = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_mul();
        logic [63:0] r; logic [4:0] d; int lat, w; logic sa, sg, sd;
        run_op(OP_MUL, 64'd3, -64'sd5, 5'd7, r, d, lat, sa, sg, sd, w);
        tests_run++; if (r !== 64'hFFFF_FFFF_FFFF_FFF1) begin tests_failed++; $display("FAIL mul_res got %h want fffffffffffffff1", r); end
        tests_run++; if (lat !== 1) begin tests_failed++; $display("FAIL mul_latency got %0d want 1", lat); end
        tests_run++; if (d !== 5'd7) begin tests_failed++; $display("FAIL mul_dr got %0d want 7", d); end
        tests_run++; if ({sa, sd} !== 2'b10) begin tests_failed++; $display("FAIL mul_stall accept/done got %b want 10", {sa, sd}); end
        @(posedge CLK); #1;
        tests_run++; if (bus.RES_V !== 1'b0) begin tests_failed++; $display("FAIL mul_res_v_one_cycle got %b want 0", bus.RES_V); end
        tests_run++; if (bus.REQ_READY !== 1'b1) begin tests_failed++; $display("FAIL mul_ready_after got %b want 1", bus.REQ_READY); end
        tests_run++; if (bus.RES !== 64'hFFFF_FFFF_FFFF_FFF1) begin tests_failed++; $display("FAIL mul_res_hold got %h want fffffffffffffff1", bus.RES); end
    endtask

    task automatic test_mulh();
        logic [63:0] r; logic [4:0] d; int lat, w; logic sa, sg, sd;
        run_op(OP_MULHU, ONES, ONES, 5'd1, r, d, lat, sa, sg, sd, w);
        tests_run++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin tests_failed++; $display("FAIL mulhu_res got %h want fffffffffffffffe", r); end
        run_op(OP_MULH, ONES, ONES, 5'd2, r, d, lat, sa, sg, sd, w);
        tests_run++; if (r !== 64'd0) begin tests_failed++; $display("FAIL mulh_res got %h want 0", r); end
        run_op(OP_MULHSU, ONES, ONES, 5'd3, r, d, lat, sa, sg, sd, w);
        tests_run++; if (r !== ONES) begin tests_failed++; $display("FAIL mulhsu_res got %h want ffffffffffffffff", r); end
        run_op(OP_MULHU, 64'h1_0000_0000, 64'h3_0000_0000, 5'd4, r, d, lat, sa, sg, sd, w);
        tests_run++; if (r !== 64'd3) begin tests_failed++; $display("FAIL mulhu_small got %h want 3", r); end
    endtask

    task automatic test_div();
        logic [63:0] r; logic [4:0] d; int lat, w; logic sa, sg, sd;
        run_op(OP_DIV, -64'sd7, 64'd2, 5'd9, r, d, lat, sa, sg, sd, w);
        tests_run++; if (r !== 64'hFFFF_FFFF_FFFF_FFFD) begin tests_failed++; $display("FAIL div_res got %h want fffffffffffffffd", r); end
        tests_run++; if (lat !== 65) begin tests_failed++; $display("FAIL div_latency got %0d want 65", lat); end
        tests_run++; if ({sa, sg, sd} !== 3'b100) begin tests_failed++; $display("FAIL div_stall acc/gap/done got %b want 100", {sa, sg, sd}); end
        tests_run++; if (d !== 5'd9) begin tests_failed++; $display("FAIL div_dr got %0d want 9", d); end
        run_op(OP_REM, -64'sd7, 64'd2, 5'd10, r, d, lat, sa, sg, sd, w);
        tests_run++; if (r !== ONES) begin tests_failed++; $display("FAIL rem_res got %h want ffffffffffffffff", r); end
        run_op(OP_REMU, 64'd100, 64'd7, 5'd11, r, d, lat, sa, sg, sd, w);
        tests_run++; if (r !== 64'd2) begin tests_failed++; $display("FAIL remu_res got %h want 2", r); end
        run_op(OP_DIVU, 64'd100, 64'd7, 5'd12, r, d, lat, sa, sg, sd, w);
        tests_run++; if (r !== 64'd14) begin tests_failed++; $display("FAIL divu_res got %h want e", r); end
        run_op(OP_DIVU, ONES, 64'h8000_0000_0000_0001, 5'd13, r, d, lat, sa, sg, sd, w);
        tests_run++; if (r !== 64'd1) begin tests_failed++; $display("FAIL divu_big got %h want 1", r); end
        run_op(OP_REMU, ONES, 64'h8000_0000_0000_0001, 5'd14, r, d, lat, sa, sg, sd, w);
        tests_run++; if (r !== 64'h7FFF_FFFF_FFFF_FFFE) begin tests_failed++; $display("FAIL remu_big got %h want 7ffffffffffffffe", r); end
    endtask

    task automatic test_div_zero();
        logic [63:0] r; logic [4:0] d; int lat, w; logic sa, sg, sd;
        run_op(OP_DIVU, 64'd5, 64'd0, 5'd15, r, d, lat, sa, sg, sd, w);
        tests_run++; if (r !== ONES) begin tests_failed++; $display("FAIL divu0_res got %h want ffffffffffffffff", r); end
        tests_run++; if (lat !== 1) begin tests_failed++; $display("FAIL divu0_latency got %0d want 1", lat); end
        run_op(OP_REM, 64'd5, 64'd0, 5'd16, r, d, lat, sa, sg, sd, w);
        tests_run++; if (r !== 64'd5) begin tests_failed++; $display("FAIL rem0_res got %h want 5", r); end
    endtask

    task automatic test_overflow();
        logic [63:0] r; logic [4:0] d; int lat, w; logic sa, sg, sd;
        run_op(OP_DIV, INT_MIN, ONES, 5'd17, r, d, lat, sa, sg, sd, w);
        tests_run++; if (r !== 64'h8000_0000_0000_0000) begin tests_failed++; $display("FAIL div_ovf_res got %h want 8000000000000000", r); end
        tests_run++; if (lat !== 1) begin tests_failed++; $display("FAIL div_ovf_latency got %0d want 1", lat); end
        run_op(OP_REM, INT_MIN, ONES, 5'd18, r, d, lat, sa, sg, sd, w);
        tests_run++; if (r !== 64'd0) begin tests_failed++; $display("FAIL rem_ovf_res got %h want 0", r); end
    endtask

    task automatic test_flush();
        logic [63:0] r; logic [4:0] d; int lat, w; logic sa, sg, sd; logic seen;
        // Flush in IDLE must block acceptance.
        @(posedge CLK); #1;
        bus.REQ_V = 1'b1; bus.REQ_OP = OP_MUL; bus.REQ_A = 64'd2; bus.REQ_B = 64'd2; bus.FLUSH = 1'b1;
        #1;
        tests_run++; if (bus.MD_STALL !== 1'b0) begin tests_failed++; $display("FAIL flush_idle_stall got %b want 0", bus.MD_STALL); end
        @(posedge CLK); #1;
        bus.REQ_V = 1'b0; bus.FLUSH = 1'b0;
        tests_run++; if ({bus.REQ_READY, bus.RES_V} !== 2'b10) begin tests_failed++; $display("FAIL flush_idle_accept ready/res_v got %b want 10", {bus.REQ_READY, bus.RES_V}); end
        // Kill a divide at iteration 30.
        bus.REQ_V = 1'b1; bus.REQ_OP = OP_DIVU; bus.REQ_A = 64'd100; bus.REQ_B = 64'd7; bus.REQ_DR = 5'd20;
        @(posedge CLK); #1;
        bus.REQ_V = 1'b0;
        repeat (29) begin @(posedge CLK); #1; end
        bus.FLUSH = 1'b1;
        #1;
        tests_run++; if (bus.RES_V !== 1'b0) begin tests_failed++; $display("FAIL flush_div_res_v got %b want 0", bus.RES_V); end
        @(posedge CLK); #1;
        bus.FLUSH = 1'b0;
        tests_run++; if (bus.REQ_READY !== 1'b1) begin tests_failed++; $display("FAIL flush_ready got %b want 1", bus.REQ_READY); end
        seen = 1'b0;
        repeat (80) begin if (bus.RES_V) seen = 1'b1; @(posedge CLK); #1; end
        tests_run++; if (seen !== 1'b0) begin tests_failed++; $display("FAIL flush_no_result got %b want 0", seen); end
        run_op(OP_MUL, 64'd6, 64'd7, 5'd21, r, d, lat, sa, sg, sd, w);
        tests_run++; if (r !== 64'd42) begin tests_failed++; $display("FAIL flush_then_mul got %h want 2a", r); end
    endtask

    task automatic test_reset_mid_div();
        logic [63:0] r; logic [4:0] d; int lat, w; logic sa, sg, sd;
        @(posedge CLK); #1;
        bus.REQ_V = 1'b1; bus.REQ_OP = OP_DIVU; bus.REQ_A = 64'd100; bus.REQ_B = 64'd7; bus.REQ_DR = 5'd22;
        @(posedge CLK); #1;
        bus.REQ_V = 1'b0;
        repeat (20) begin @(posedge CLK); #1; end
        #2 RESET_N = 1'b0;
        #1;
        tests_run++; if (bus.RES !== 64'd0) begin tests_failed++; $display("FAIL async_reset_res got %h want 0", bus.RES); end
        tests_run++; if (bus.RES_DR !== 5'd0) begin tests_failed++; $display("FAIL async_reset_res_dr got %0d want 0", bus.RES_DR); end
        tests_run++; if ({bus.REQ_READY, bus.MD_STALL, bus.RES_V} !== 3'b100) begin tests_failed++; $display("FAIL async_reset_ctl ready/stall/res_v got %b want 100", {bus.REQ_READY, bus.MD_STALL, bus.RES_V}); end
        @(posedge CLK); #1 RESET_N = 1'b1;
        run_op(OP_DIVU, 64'd10, 64'd3, 5'd23, r, d, lat, sa, sg, sd, w);
        tests_run++; if (r !== 64'd3) begin tests_failed++; $display("FAIL post_reset_divu got %h want 3", r); end
        tests_run++; if (lat !== 65) begin tests_failed++; $display("FAIL post_reset_latency got %0d want 65", lat); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] r; logic [4:0] d; int lat, w; logic sa, sg, sd;
        run_op(OP_MUL, 64'd2, 64'd3, 5'd24, r, d, lat, sa, sg, sd, w);
        run_op(OP_MUL, 64'd4, 64'd5, 5'd25, r, d, lat, sa, sg, sd, w);
        tests_run++; if (w !== 1) begin tests_failed++; $display("FAIL b2b_bubble got %0d want 1", w); end
        tests_run++; if ({r, d} !== {64'd20, 5'd25}) begin tests_failed++; $display("FAIL b2b_res got %h/%0d want 14/25", r, d); end
    endtask

    initial begin
        bus.REQ_V = 1'b0; bus.REQ_OP = 3'd0; bus.REQ_A = '0; bus.REQ_B = '0; bus.REQ_DR = '0; bus.FLUSH = 1'b0;
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_div_zero();
        test_overflow();
        test_flush();
        test_reset_mid_div();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle controller for the RISC-V M-extension, sitting beside the execute stage. It accepts one multiply/divide request at a time, stalls the front of the pipeline while busy, and returns a registered result with the destination register.
- Multiplies complete in one cycle.
- Divides and remainders run a 64-iteration restoring divider, sequenced by an internal FSM.
- Divide-by-zero and signed overflow are short-circuited.

## Interface
Parameters:
- XLEN, 64, operand/result width
- CNT_W, 6, iteration counter width (log2 XLEN)

Ports (one clock; reset is asynchronous and active-low):
- CLK  in  1  clock, all state updates on rising edge
- RESET_N  in  1  asynchronous active-low reset
- REQ_V  in  1  request valid
- REQ_OP  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- REQ_A  in  XLEN  rs1 operand
- REQ_B  in  XLEN  rs2 operand
- REQ_DR  in  5  destination register
- FLUSH  in  1  kill in-flight op (branch redirect)
- REQ_READY  out  1  state==IDLE
- MD_STALL  out  1  (state==IDLE && REQ_V && !FLUSH) || state==DIV
- RES_V  out  1  (state==DONE) && !FLUSH
- RES  out  XLEN  result, valid when RES_V
- RES_DR  out  5  destination of RES

## Operation
States and transitions:
- IDLE: a request is accepted when REQ_V && REQ_READY && !FLUSH.
  - Captures A, B, OP, DR.
  - MUL* goes to DONE; the product is registered at acceptance.
  - DIV*/REM* with B==0 goes to DONE. Results: quotient all-ones; remainder = A.
  - DIV/REM with A==0x8000_0000_0000_0000 and B==all-ones goes to DONE. Results: quotient = A; remainder 0.
  - Otherwise goes to DIV, with count=XLEN-1 and partial remainder 0.
- DIV: restoring divide, one quotient bit per cycle.
  - Shift the remainder left, appending the next dividend MSB.
  - If remainder ≥ |divisor|, subtract and set the quotient bit.
  - When count==0 the iteration completes and the state goes to DONE.
- DONE: RES_V high for exactly one cycle; unconditionally returns to IDLE.

Arithmetic rules:
- MUL: low XLEN bits of the product.
- MULH: high half, signed×signed.
- MULHSU: high half, signed×unsigned.
- MULHU: high half, unsigned×unsigned.
- Signed divide uses the unsigned core on magnitudes:
  - quotient is negated if the operand signs differ;
  - remainder takes the dividend's sign;
  - fixup happens on the DIV→DONE edge.

FLUSH:
- In any state, FLUSH forces IDLE at the next edge.
- In the same cycle it suppresses RES_V and blocks acceptance.

Reset (any state, including mid-division):
- state=IDLE, count=0.
- RES=0, RES_DR=0, so RES_V=0.
- Operand registers are cleared.

REQ_V is ignored in DIV and DONE. The pipeline holds the request stable while MD_STALL=1 and advances during DONE.

## Timing
- Acceptance at edge k:
  - MUL* or special-case divide: RES_V during cycle k→k+1 (latency 1).
  - Normal divide: iterations on edges k+1..k+64; RES_V during cycle k+64→k+65 (latency 65).
- MD_STALL:
  - High in the accept cycle and in all DIV cycles.
  - Low in DONE, so the held instruction retires with RES.
- REQ_READY:
  - Returns high the cycle after DONE.
  - Back-to-back ops are possible with one bubble.
- RES/RES_DR stay stable from DONE until the next acceptance.

## Structure
- Package muldiv_pkg:
  - op encoding localparams (OP_MUL..OP_REMU);
  - state enum {IDLE, DIV, DONE};
  - XLEN default;
  - constant INT_MIN.
- Sub-module divu_iter: combinational single restoring step.
  - Inputs: rem, dividend bit, divisor.
  - Outputs: next rem, quotient bit.
- FSM, counter, sign fixup and multiplier live in muldiv_sequencer.

## Test plan
- MUL A=3, B=-5 → RES_V one cycle after accept; RES=0xFFFF_FFFF_FFFF_FFF1; MD_STALL=1 for one cycle only.
- MULHU A=B=all-ones → RES=0xFFFF_FFFF_FFFF_FFFE.
- MULH A=B=all-ones → RES=0.
- DIV A=-7, B=2 → RES_V exactly 65 cycles after accept; RES=0xFFFF_FFFF_FFFF_FFFD.
- REM A=-7, B=2 → RES=all-ones.
- REMU A=100, B=7 → RES=2.
- DIVU A=5, B=0 → RES=all-ones with latency 1.
- REM A=5, B=0 → RES=5.
- DIV A=0x8000_0000_0000_0000, B=-1 → RES=0x8000_0000_0000_0000.
- REM A=0x8000_0000_0000_0000, B=-1 → RES=0.
- FLUSH at iteration 30 of a DIV:
  - no RES_V; REQ_READY=1 the next cycle;
  - a following MUL 6×7 gives RES=42.
- RESET_N low mid-division (asynchronous, between edges):
  - outputs go to reset values immediately;
  - after release, a DIVU 10/3 gives RES=3.
